// File: rtl/nib_lane_addsub.sv
// Two-stage packed-nibble adder/subtractor: four independent 4-bit lanes with no
// inter-lane carry, valid/ready handshake on both sides and a pipeline flush.
module nib_lane_addsub (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] psum,
  output logic [3:0]  carry1,
  output logic        out_sub
);

  logic        v1;
  logic        v2;
  logic [15:0] s1_a;
  logic [15:0] s1_b;
  logic        s1_sub;
  logic [15:0] s2_psum;
  logic [3:0]  s2_carry;
  logic        s2_sub;

  logic        s2_load;
  logic        accept;
  logic [15:0] lane_sum;
  logic [3:0]  lane_cy;
  logic [4:0]  lane_res;

  always_comb begin
    s2_load  = v1 & (~v2 | out_ready);
    in_ready = ~v1 | s2_load;
    accept   = in_valid & in_ready & ~flush;
  end

  // Subtraction is a + ~b + 1, so the lane carry-out reads as "no borrow".
  always_comb begin
    lane_sum = '0;
    lane_cy  = '0;
    lane_res = '0;
    for (int i = 0; i < 4; i++) begin
      lane_res = {1'b0, s1_a[4*i +: 4]}
               + {1'b0, (s1_sub ? ~s1_b[4*i +: 4] : s1_b[4*i +: 4])}
               + {4'b0000, s1_sub};
      lane_sum[4*i +: 4] = lane_res[3:0];
      lane_cy[i]         = lane_res[4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sub   <= 1'b0;
      s2_psum  <= '0;
      s2_carry <= '0;
      s2_sub   <= 1'b0;
    end else begin
      if (flush) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
      end else begin
        v1 <= accept | (v1 & ~s2_load);
        v2 <= s2_load | (v2 & ~out_ready);
      end
      // Data registers are never cleared by flush; the valid bits alone squash.
      if (accept) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_sub <= sub;
      end
      if (s2_load) begin
        s2_psum  <= lane_sum;
        s2_carry <= lane_cy;
        s2_sub   <= s1_sub;
      end
    end
  end

  assign out_valid = v2;
  assign psum      = s2_psum;
  assign carry1    = s2_carry;
  assign out_sub   = s2_sub;

endmodule

// File: tb/tb_nib_lane_addsub.sv
// Randomized and directed bench for nib_lane_addsub against an occupancy/queue
// reference model with per-lane integer arithmetic.
module tb_nib_lane_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] psum;
  logic [3:0]  carry1;
  logic        out_sub;

  nib_lane_addsub dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .psum(psum), .carry1(carry1), .out_sub(out_sub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [20:0] q[$];
  bit          acc_last = 0;
  bit          model_ok = 0;
  bit          exp_ir;
  bit          exp_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, want, $time);
    end
  endtask

  // Expected {out_sub, carry1, psum} from plain per-lane integer arithmetic.
  function automatic logic [20:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic s);
    logic [15:0] p;
    logic [3:0]  c;
    int ai, bi, r;
    p = '0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      ai = int'(x[4*i +: 4]);
      bi = int'(y[4*i +: 4]);
      r  = s ? (ai - bi + 16) : (ai + bi);
      p[4*i +: 4] = r[3:0];
      c[i] = (r >= 16);
    end
    return {s, c, p};
  endfunction

  // One clock: inputs must already be driven; checks at negedge, model updates at posedge.
  task automatic step();
    bit fire_in;
    bit fire_out;
    logic [20:0] e;
    @(negedge clk);
    exp_ir = (q.size() < 2) || out_ready;
    exp_ov = (q.size() == 2) || (q.size() == 1 && !acc_last);
    if (model_ok) begin
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        e = q[0];
        chk("psum", psum, e[15:0]);
        chk("carry1", carry1, e[19:16]);
        chk("out_sub", out_sub, e[20]);
      end
    end
    fire_in  = in_valid && exp_ir && !flush;
    fire_out = exp_ov && out_ready;
    e = ref_op(a, b, sub);
    @(posedge clk);
    if (rst) begin
      q.delete();
      acc_last = 0;
      model_ok = 1;
    end else if (model_ok) begin
      if (fire_out) void'(q.pop_front());
      if (flush) begin
        q.delete();
        acc_last = 0;
      end else begin
        if (fire_in) q.push_back(e);
        acc_last = fire_in;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic s);
    in_valid = v;
    a = x;
    b = y;
    sub = s;
  endtask

  logic [15:0] bp_a[4];
  logic [15:0] bp_b[4];
  int          idx;
  int          accepted;
  int          budget;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    rst = 1'b0;
    chk("rst_psum", psum, 16'h0000);
    chk("rst_carry1", carry1, 4'h0);
    chk("rst_out_sub", out_sub, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Add with two-cycle latency
    drive(1'b1, 16'h1234, 16'h0F0F, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    chk("add_valid", out_valid, 1'b1);
    chk("add_psum", psum, 16'h1133);
    chk("add_carry1", carry1, 4'b0101);
    chk("add_out_sub", out_sub, 1'b0);

    // Back-to-back subtracts
    drive(1'b1, 16'h5555, 16'h1234, 1'b1);
    step();
    drive(1'b1, 16'h0000, 16'h0001, 1'b1);
    step();
    chk("sub1_psum", psum, 16'h4321);
    chk("sub1_carry1", carry1, 4'b1111);
    chk("sub1_out_sub", out_sub, 1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    chk("sub2_psum", psum, 16'h000F);
    chk("sub2_carry1", carry1, 4'b1110);
    step();
    step();

    // Backpressure: four ops against a stalled sink
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    accepted = 0;
    budget = 0;
    while (accepted < 2 && budget < 10) begin
      drive(1'b1, bp_a[idx], bp_b[idx], idx[0]);
      if (exp_ir || !model_ok) ;
      if ((q.size() < 2) || out_ready) begin
        idx++;
        accepted++;
      end
      step();
      budget++;
    end
    chk("bp_accepts", 32'(accepted), 32'd2);
    drive(1'b1, bp_a[idx], bp_b[idx], idx[0]);
    chk("bp_in_ready_low", in_ready, 1'b0);
    step();
    step();
    chk("bp_hold_psum", psum, {16'h0, ref_op(bp_a[0], bp_b[0], 1'b0)} & 32'hFFFF);
    out_ready = 1'b1;
    budget = 0;
    while (idx < 4 && budget < 10) begin
      drive(1'b1, bp_a[idx], bp_b[idx], idx[0]);
      idx++;
      step();
      budget++;
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    step();
    chk("bp_drained", out_valid, 1'b0);

    // Flush with two ops in flight and a new op presented
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'h2222, 1'b0);
    step();
    drive(1'b1, 16'h3333, 16'h4444, 1'b1);
    step();
    flush = 1'b1;
    drive(1'b1, 16'hABCD, 16'h1234, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    step();
    chk("flush_no_ghost", out_valid, 1'b0);

    // Reset with a full pipeline
    out_ready = 1'b0;
    drive(1'b1, 16'h9876, 16'h5432, 1'b1);
    step();
    drive(1'b1, 16'hFEDC, 16'hBA98, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    chk("mrst_psum", psum, 16'h0000);
    chk("mrst_carry1", carry1, 4'h0);
    chk("mrst_out_sub", out_sub, 1'b0);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    drive(1'b1, 16'hF0F0, 16'h0F0F, 1'b0);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    chk("mrst_lat1", out_valid, 1'b0);
    step();
    chk("mrst_lat2", out_valid, 1'b1);
    chk("mrst_psum2", psum, 16'hFFFF);
    step();

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    step();
    chk("final_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
